// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller with a double-buffered display word.
// Optional leading-zero suppression is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan_ctrl #(
    parameter int N_DIGITS       = 8,
    parameter int DIV            = 50000,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    Rst,
    input  logic [4*N_DIGITS-1:0]   din,
    input  logic                    load,
    input  logic [N_DIGITS-1:0]     blank_mask,
    input  logic [N_DIGITS-1:0]     dp,
    output logic [N_DIGITS-1:0]     an,
    output logic [6:0]              sev_out,
    output logic                    dp_out,
    output logic                    frame_done,
    output logic                    upd_pending
);

    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [N_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};
    localparam logic [6:0]          SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                DP_OFF  = (SEG_ACTIVE_LOW != 0);

    logic [PW-1:0]           r_presc;
    logic [IW-1:0]           r_idx;
    logic [4*N_DIGITS-1:0]   r_stage;
    logic [4*N_DIGITS-1:0]   r_shadow;
    logic                    r_pending;
    logic [N_DIGITS-1:0]     r_an;
    logic [6:0]              r_sev;
    logic                    r_dp;
    logic                    r_frame_done;

    logic                    w_tick;
    logic                    w_last;
    logic                    w_boundary;
    logic [IW-1:0]           w_idx_nxt;
    logic [4*N_DIGITS-1:0]   w_shadow_nxt;
    logic [3:0]              w_digit;
    logic                    w_blank_live;
    logic                    w_dp_sel;
    logic                    w_lz;
    logic                    w_blank;
    logic [6:0]              w_seg_al;
    logic [N_DIGITS-1:0]     w_an_on;
    logic [N_DIGITS-1:0]     w_an_nxt;
    logic [6:0]              w_sev_nxt;
    logic                    w_dp_nxt;

    assign w_tick     = (r_presc == PW'(DIV - 1));
    assign w_last     = (r_idx == IW'(N_DIGITS - 1));
    assign w_boundary = w_tick & w_last;
    assign w_idx_nxt  = w_last ? '0 : r_idx + IW'(1);

    // Value the shadow takes at this edge; digit 0 of a new frame reads it directly.
    always_comb begin
        w_shadow_nxt = r_shadow;
        if (w_boundary) begin
            if (load)
                w_shadow_nxt = din;
            else if (r_pending)
                w_shadow_nxt = r_stage;
        end
    end

    always_comb begin
        w_digit      = 4'h0;
        w_blank_live = 1'b0;
        w_dp_sel     = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (IW'(i) == w_idx_nxt) begin
                w_digit      = w_shadow_nxt[4*i +: 4];
                w_blank_live = blank_mask[i];
                w_dp_sel     = dp[i];
            end
        end
    end

`ifdef SEG7_LZ_BLANK_EN
    logic [IW-1:0] w_lz_lim;
    always_comb begin
        w_lz_lim = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (w_shadow_nxt[4*i +: 4] != 4'h0)
                w_lz_lim = IW'(i);
        end
    end
    assign w_lz = (w_idx_nxt > w_lz_lim);
`else
    assign w_lz = 1'b0;
`endif

    assign w_blank = w_blank_live | w_lz;

    always_comb begin
        case (w_digit)
            4'h0: w_seg_al = 7'b0000001;
            4'h1: w_seg_al = 7'b1001111;
            4'h2: w_seg_al = 7'b0010010;
            4'h3: w_seg_al = 7'b0000110;
            4'h4: w_seg_al = 7'b1001100;
            4'h5: w_seg_al = 7'b0100100;
            4'h6: w_seg_al = 7'b0100000;
            4'h7: w_seg_al = 7'b0001111;
            4'h8: w_seg_al = 7'b0000000;
            4'h9: w_seg_al = 7'b0000100;
            4'hA: w_seg_al = 7'b0001000;
            4'hB: w_seg_al = 7'b1100000;
            4'hC: w_seg_al = 7'b0110001;
            4'hD: w_seg_al = 7'b1000010;
            4'hE: w_seg_al = 7'b0110000;
            default: w_seg_al = 7'b0111000;
        endcase
    end

    always_comb begin
        w_an_on   = w_blank ? '0 : (N_DIGITS'(1) << w_idx_nxt);
        w_an_nxt  = (AN_ACTIVE_LOW != 0) ? ~w_an_on : w_an_on;
        w_sev_nxt = w_blank ? SEG_OFF : ((SEG_ACTIVE_LOW != 0) ? w_seg_al : ~w_seg_al);
        w_dp_nxt  = (w_blank || !w_dp_sel) ? DP_OFF : ~DP_OFF;
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            r_presc      <= '0;
            r_idx        <= IW'(N_DIGITS - 1);
            r_stage      <= '0;
            r_shadow     <= '0;
            r_pending    <= 1'b0;
            r_an         <= AN_OFF;
            r_sev        <= SEG_OFF;
            r_dp         <= DP_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_presc      <= w_tick ? '0 : r_presc + PW'(1);
            r_frame_done <= w_boundary;
            r_shadow     <= w_shadow_nxt;
            if (w_tick) begin
                r_idx <= w_idx_nxt;
                r_an  <= w_an_nxt;
                r_sev <= w_sev_nxt;
                r_dp  <= w_dp_nxt;
            end
            // A load landing on the boundary goes straight to the shadow, so nothing stays pending.
            if (w_boundary)
                r_pending <= 1'b0;
            else if (load) begin
                r_stage   <= din;
                r_pending <= 1'b1;
            end
        end
    end

    assign an          = r_an;
    assign sev_out     = r_sev;
    assign dp_out      = r_dp;
    assign frame_done  = r_frame_done;
    assign upd_pending = r_pending;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl at N_DIGITS=4, DIV=4; a second instance covers inverted polarities.
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        Rst = 1'b1;
    logic [15:0] din = '0;
    logic        load = 1'b0;
    logic [3:0]  blank_mask = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  an, an_p;
    logic [6:0]  sev_out, sev_p;
    logic        dp_out, dp_p;
    logic        frame_done, fd_p;
    logic        upd_pending, up_p;

    int n_vec = 0;
    int n_bad = 0;

    localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010, S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100, S5 = 7'b0100100, S7 = 7'b0001111, S8 = 7'b0000000;
    localparam logic [6:0] SD = 7'b1000010, SOFF = 7'b1111111;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.N_DIGITS(4), .DIV(4), .AN_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)) dut (
        .clk(clk), .Rst(Rst), .din(din), .load(load), .blank_mask(blank_mask), .dp(dp),
        .an(an), .sev_out(sev_out), .dp_out(dp_out), .frame_done(frame_done), .upd_pending(upd_pending)
    );

    seg7_scan_ctrl #(.N_DIGITS(4), .DIV(4), .AN_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(0)) dut_pos (
        .clk(clk), .Rst(Rst), .din(din), .load(load), .blank_mask(blank_mask), .dp(dp),
        .an(an_p), .sev_out(sev_p), .dp_out(dp_p), .frame_done(fd_p), .upd_pending(up_p)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle just after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_slot(input string tag, input logic [3:0] e_an, input logic [6:0] e_sev);
        check_vec({tag, "_an"}, {28'd0, an}, {28'd0, e_an});
        check_vec({tag, "_sev"}, {25'd0, sev_out}, {25'd0, e_sev});
    endtask

    initial begin
        step(2);
        Rst = 1'b0;
        // p counts edges since reset release; digit slots start at p = 4, 8, 12, ...
        check_vec("rst_an", {28'd0, an}, 32'hF);
        check_vec("rst_sev", {25'd0, sev_out}, 32'h7F);
        check_vec("rst_dp", {31'd0, dp_out}, 32'h1);
        check_vec("rst_fd", {31'd0, frame_done}, 32'h0);
        check_vec("rst_up", {31'd0, upd_pending}, 32'h0);
        check_vec("rst_an_pos", {28'd0, an_p}, 32'h0);
        check_vec("rst_sev_pos", {25'd0, sev_p}, 32'h0);
        step(3);                                   // p=3
        chk_slot("pre_first", 4'hF, SOFF);
        check_vec("pre_first_fd", {31'd0, frame_done}, 32'h0);
        step(1);                                   // p=4
        chk_slot("first", 4'hE, S0);
        check_vec("first_fd", {31'd0, frame_done}, 32'h1);
        check_vec("first_an_pos", {28'd0, an_p}, 32'h1);
        check_vec("first_sev_pos", {25'd0, sev_p}, {25'd0, ~S0});
        step(1);                                   // p=5
        check_vec("fd_pulse", {31'd0, frame_done}, 32'h0);

        din = 16'h1234; load = 1'b1;
        step(1);                                   // p=6
        load = 1'b0;
        check_vec("pend_set", {31'd0, upd_pending}, 32'h1);
        step(3);                                   // p=9
        chk_slot("old_s1", 4'hD, S0);
        step(11);                                  // p=20
        chk_slot("f1_s0", 4'hE, S4);
        check_vec("f1_fd", {31'd0, frame_done}, 32'h1);
        check_vec("f1_up", {31'd0, upd_pending}, 32'h0);
        step(4); chk_slot("f1_s1", 4'hD, S3);      // p=24
        step(4); chk_slot("f1_s2", 4'hB, S2);      // p=28
        step(4); chk_slot("f1_s3", 4'h7, S1);      // p=32
        step(8); chk_slot("f2_s1", 4'hD, S3);      // p=40

        din = 16'hABCD;
        step(1); load = 1'b1;                      // p=41
        step(1); load = 1'b0;                      // p=42
        check_vec("abcd_pend", {31'd0, upd_pending}, 32'h1);
        step(2); chk_slot("keep_s2", 4'hB, S2);    // p=44
        step(4); chk_slot("keep_s3", 4'h7, S1);    // p=48
        step(4);                                   // p=52
        chk_slot("wrap_D", 4'hE, SD);
        check_vec("wrap_up", {31'd0, upd_pending}, 32'h0);

        step(1); din = 16'h1111; load = 1'b1;      // p=53
        step(1); load = 1'b0;                      // p=54
        step(1); din = 16'h2222; load = 1'b1;      // p=55
        step(1); load = 1'b0;                      // p=56
        step(12); chk_slot("last_wins_s0", 4'hE, S2); // p=68
        step(4); chk_slot("last_wins_s1", 4'hD, S2);  // p=72

        step(11); din = 16'h5678; load = 1'b1;     // p=83
        step(1); load = 1'b0;                      // p=84
        chk_slot("bnd_load", 4'hE, S8);
        check_vec("bnd_load_up", {31'd0, upd_pending}, 32'h0);
        check_vec("bnd_load_fd", {31'd0, frame_done}, 32'h1);

        blank_mask = 4'b0100; dp = 4'b0001;
        step(4);                                   // p=88
        chk_slot("s1_7", 4'hD, S7);
        check_vec("s1_dp", {31'd0, dp_out}, 32'h1);
        step(4);                                   // p=92
        chk_slot("blank_s2", 4'hF, SOFF);
        check_vec("blank_dp", {31'd0, dp_out}, 32'h1);
        check_vec("blank_an_pos", {28'd0, an_p}, 32'h0);
        din = 16'h9999; load = 1'b1;
        step(1); load = 1'b0; Rst = 1'b1;          // p=93, staged 9999 pending
        check_vec("stage_pend", {31'd0, upd_pending}, 32'h1);
        step(1);
        chk_slot("midrst", 4'hF, SOFF);
        check_vec("midrst_dp", {31'd0, dp_out}, 32'h1);
        check_vec("midrst_up", {31'd0, upd_pending}, 32'h0);
        check_vec("midrst_fd", {31'd0, frame_done}, 32'h0);
        Rst = 1'b0;                                // q counts edges since this release
        step(4);                                   // q=4
        chk_slot("post_rst", 4'hE, S0);
        check_vec("dp0_lit", {31'd0, dp_out}, 32'h0);
        check_vec("dp0_lit_pos", {31'd0, dp_p}, 32'h1);

        blank_mask = 4'b0000; dp = 4'b0000;
        din = 16'h0050; load = 1'b1;
        step(1); load = 1'b0;                      // q=5
        step(15);                                  // q=20
        chk_slot("lz_s0", 4'hE, S0);
        step(4); chk_slot("lz_s1", 4'hD, S5);      // q=24
        step(4);                                   // q=28
`ifdef SEG7_LZ_BLANK_EN
        chk_slot("lz_s2", 4'hF, SOFF);
        step(4); chk_slot("lz_s3", 4'hF, SOFF);
`else
        chk_slot("lz_s2", 4'hB, S0);
        step(4); chk_slot("lz_s3", 4'h7, S0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
